// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline.
//
// Each stage holds a valid bit and a data word. A stage advances when it is
// empty or when the stage in front of it advances, so bubbles collapse and
// full throughput (one word per cycle) is sustained under out_ready=1.
//
// Optional feature macro: DFF_PIPE_PARITY_EN
//   defined   : an even-parity bit of d is captured at stage 0 and moves with
//               the data; perr flags a mismatch at the output stage.
//   undefined : no parity storage, perr tied to 0.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears all valid, data, count)
//   in_valid  upstream data valid
//   in_ready  pipeline can accept d this cycle
//   d         upstream data
//   out_valid last stage holds valid data
//   out_ready downstream accepts q this cycle
//   q         last-stage data
//   flush     synchronous clear of all stage valid bits and count
//   count     number of valid stages
//   perr      parity error on output (0 unless DFF_PIPE_PARITY_EN)
module dff_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  input  logic             flush,
  output logic [CNTW-1:0]  count,
  output logic             perr
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [CNTW-1:0]  count_q;
  logic [CNTW-1:0]  count_d;
  logic             in_xfer;
  logic             out_xfer;

  // Ready chain, evaluated from the output stage back toward the input.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~vld_q[DEPTH-1] | out_ready;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      adv[DEPTH-1-k] = ~vld_q[DEPTH-1-k] | adv[DEPTH-k];
    end
  end

  assign in_ready  = adv[0];
  assign in_xfer   = in_valid & adv[0];
  assign out_xfer  = vld_q[DEPTH-1] & out_ready;
  assign out_valid = vld_q[DEPTH-1];
  assign q         = dat_q[DEPTH-1];
  assign count     = count_q;

  // Data words only load behind a valid bit, so empty slots keep stale data.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (adv[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        dat_d[0] = d;
      end
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_d[k] = dat_q[k-1];
        end
      end
    end
    // The output word still leaves on a flush cycle; only valid bits clear.
    if (flush) begin
      vld_d = '0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNTW'(in_xfer) - CNTW'(out_xfer);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] par_d;

  // Parity follows exactly the same load/hold rules as the data words.
  always_comb begin
    par_d = par_q;
    if (adv[0] && in_valid) begin
      par_d[0] = ^d;
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (adv[k] && vld_q[k-1]) begin
        par_d[k] = par_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign perr = vld_q[DEPTH-1] & ((^dat_q[DEPTH-1]) != par_q[DEPTH-1]);
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             flush;
  logic [CNTW-1:0]  count;
  logic             perr;

  int total;
  int bad;

  // Reference model: words in flight, oldest first, each with its stage index.
  logic [WIDTH-1:0] mdat[$];
  int               mpos[$];

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .flush     (flush),
    .count     (count),
    .perr      (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic bit m_in_ready();
    return !((mpos.size() == DEPTH) && !out_ready);
  endfunction

  function automatic bit m_out_valid();
    return (mpos.size() > 0) && (mpos[0] == DEPTH - 1);
  endfunction

  // One clock edge: the model moves every word forward as far as the word in
  // front of it allows, drops the head if taken, then applies flush/input.
  task automatic tick();
    bit m_out;
    bit m_in;
    int bound;
    int np;
    m_out = m_out_valid() && out_ready;
    m_in  = in_valid && m_in_ready();
    @(posedge clk);
    if (m_out) begin
      void'(mdat.pop_front());
      void'(mpos.pop_front());
    end
    bound = DEPTH - 1;
    for (int j = 0; j < mpos.size(); j++) begin
      np = mpos[j] + 1;
      if (np > bound) np = bound;
      mpos[j] = np;
      bound = np - 1;
    end
    if (flush) begin
      mdat.delete();
      mpos.delete();
    end else if (m_in) begin
      mdat.push_back(d);
      mpos.push_back(0);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    d         = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", q); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", perr); end
    @(negedge clk);
    rst_n = 1'b1;
    mdat.delete();
    mpos.delete();
    @(negedge clk);
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] exp_q [3];
    int exp_cnt [3];
    exp_q[0] = 8'h22; exp_q[1] = 8'h33;
    exp_cnt[0] = 2; exp_cnt[1] = 1;
    idle_inputs();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    d = 8'h11; tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_early1 got=%b want=0", out_valid); end
    d = 8'h22; tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_early2 got=%b want=0", out_valid); end
    d = 8'h33; tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || q !== 8'h11) begin bad++; $display("FAIL stream_first got=%b/%h want=1/11", out_valid, q); end
    total++; if (count !== 2'd3) begin bad++; $display("FAIL stream_peak got=%0d want=3", count); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (out_valid !== 1'b1 || q !== exp_q[i]) begin bad++; $display("FAIL stream_word%0d got=%b/%h want=1/%h", i + 1, out_valid, q, exp_q[i]); end
      total++; if (count !== CNTW'(exp_cnt[i])) begin bad++; $display("FAIL stream_count%0d got=%0d want=%0d", i + 1, count, exp_cnt[i]); end
    end
    tick();
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL stream_drain got=%b/%0d want=0/0", out_valid, count); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] exp_q [3];
    exp_q[0] = 8'hA2; exp_q[1] = 8'hA3; exp_q[2] = 8'hA4;
    idle_inputs();
    in_valid = 1'b1;
    d = 8'hA1; tick();
    d = 8'hA2; tick();
    d = 8'hA3; tick();
    d = 8'hA4;
    #1;
    total++; if (count !== 2'd3) begin bad++; $display("FAIL bp_full_count got=%0d want=3", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_low got=%b want=0", in_ready); end
    tick();
    total++; if (count !== 2'd3 || q !== 8'hA1) begin bad++; $display("FAIL bp_hold got=%0d/%h want=3/a1", count, q); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_high got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (count !== 2'd3) begin bad++; $display("FAIL bp_swap_count got=%0d want=3", count); end
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || q !== exp_q[i]) begin bad++; $display("FAIL bp_order%0d got=%b/%h want=1/%h", i, out_valid, q, exp_q[i]); end
      tick();
    end
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL bp_empty got=%b/%0d want=0/0", out_valid, count); end
  endtask

  task automatic test_bubble();
    idle_inputs();
    in_valid = 1'b1; d = 8'h05; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; d = 8'h06; tick();
    in_valid = 1'b0; tick();
    total++; if (count !== 2'd2) begin bad++; $display("FAIL bubble_count got=%0d want=2", count); end
    total++; if (out_valid !== 1'b1 || q !== 8'h05) begin bad++; $display("FAIL bubble_head got=%b/%h want=1/05", out_valid, q); end
    total++; if (mpos.size() != 2 || mpos[1] != 1) begin bad++; $display("FAIL bubble_model_packing got=%0d want=2", mpos.size()); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || q !== 8'h06) begin bad++; $display("FAIL bubble_second got=%b/%h want=1/06", out_valid, q); end
    tick();
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL bubble_empty got=%b/%0d want=0/0", out_valid, count); end
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1'b1; d = 8'h31; tick();
    d = 8'h32; tick();
    total++; if (count !== 2'd2) begin bad++; $display("FAIL flush_pre_count got=%0d want=2", count); end
    d = 8'h7E; flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
    tick();
    idle_inputs();
    total++; if (count !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0d/%b want=0/0", count, out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_emerge%0d got=%b/%h want=0", i, out_valid, q); end
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    in_valid = 1'b1;
    d = 8'hC1; tick();
    d = 8'hC2; tick();
    d = 8'hC3; tick();
    in_valid = 1'b0;
    total++; if (count !== 2'd3 || q !== 8'hC1) begin bad++; $display("FAIL areset_pre got=%0d/%h want=3/c1", count, q); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || q !== 8'h00) begin bad++; $display("FAIL areset_out got=%b/%h want=0/00", out_valid, q); end
    total++; if (count !== 2'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL areset_cnt_rdy got=%0d/%b want=0/1", count, in_ready); end
    mdat.delete();
    mpos.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit exp_v;
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      d         = 8'($urandom);
      #1;
      total++; if (in_ready !== m_in_ready()) begin bad++; $display("FAIL rnd_in_ready@%0d got=%b want=%b", i, in_ready, m_in_ready()); end
      tick();
      exp_v = m_out_valid();
      total++; if (out_valid !== exp_v) begin bad++; $display("FAIL rnd_out_valid@%0d got=%b want=%b", i, out_valid, exp_v); end
      total++; if (count !== CNTW'(mpos.size())) begin bad++; $display("FAIL rnd_count@%0d got=%0d want=%0d", i, count, mpos.size()); end
      if (exp_v) begin
        total++; if (q !== mdat[0]) begin bad++; $display("FAIL rnd_q@%0d got=%h want=%h", i, q, mdat[0]); end
      end
      total++; if (perr !== 1'b0) begin bad++; $display("FAIL rnd_perr@%0d got=%b want=0", i, perr); end
    end
    idle_inputs();
  endtask

`ifdef DFF_PIPE_PARITY_EN
  task automatic test_parity();
    idle_inputs();
    in_valid = 1'b1; d = 8'h0F; tick();
    in_valid = 1'b0; tick();
    dut.dat_q[1][0] = ~dut.dat_q[1][0];
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || q !== 8'h0E || perr !== 1'b1) begin bad++; $display("FAIL parity_flip got=%b/%h/%b want=1/0e/1", out_valid, q, perr); end
    tick();
    in_valid = 1'b1; d = 8'h0F; tick();
    in_valid = 1'b0; tick(); tick();
    total++; if (out_valid !== 1'b1 || q !== 8'h0F || perr !== 1'b0) begin bad++; $display("FAIL parity_clean got=%b/%h/%b want=1/0f/0", out_valid, q, perr); end
    tick();
    idle_inputs();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
`ifdef DFF_PIPE_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
